// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants and coordinate type for the VGA pipeline.
// Also used by the colour stage.
package vga_timing_pkg;

  localparam int COORD_W  = 10;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;

  localparam int H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP;

  typedef logic [COORD_W-1:0] coord_t;

  function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between the timing generator (master) and the colour stage (slave).
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  logic   en;
  logic   pix_ce;
  logic   hsync;
  logic   vsync;
  logic   de;
  coord_t x;
  coord_t y;
  logic   line_start;
  logic   frame_start;

  modport master (
    input  en,
    output pix_ce, hsync, vsync, de, x, y, line_start, frame_start
  );

  modport slave (
    output en,
    input  pix_ce, hsync, vsync, de, x, y, line_start, frame_start
  );

endinterface

// File: rtl/vga_axis_cnt.sv
// One raster axis: wrapping position counter with active-area and sync-window decode.
// sync_o is the raw window (active-high); polarity is applied by the caller.
module vga_axis_cnt
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   clr_i,
  input  logic   inc_i,
  output coord_t cnt_o,
  output logic   first_o,
  output logic   active_o,
  output logic   sync_o
);

  localparam int TOT = axis_total(ACTIVE, FP, SYNC, BP);

  coord_t cnt_q, cnt_d;
  logic   last;

  assign last = (cnt_q == coord_t'(TOT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = last ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o    = cnt_q;
  assign first_o  = (cnt_q == '0);
  assign active_o = (cnt_q < coord_t'(ACTIVE));
  assign sync_o   = (cnt_q >= coord_t'(ACTIVE + FP)) && (cnt_q < coord_t'(ACTIVE + FP + SYNC));

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel clock-enable divider, h/v counters, registered sync/de/coords.
// Every decoded output is registered on the divider tick, so it describes the slot marked by pix_ce.
module vga_timing_gen #(
  parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int H_FP     = vga_timing_pkg::H_FP,
  parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int H_BP     = vga_timing_pkg::H_BP,
  parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int V_FP     = vga_timing_pkg::V_FP,
  parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int V_BP     = vga_timing_pkg::V_BP,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CE_DIV   = 2
) (
  input logic              clk,
  input logic              rst,
  vga_timing_gen_if.master vga
);
  import vga_timing_pkg::coord_t;
  import vga_timing_pkg::COORD_W;
  import vga_timing_pkg::axis_total;

  localparam int H_TOT_L = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOT_L = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int CE_W    = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
  localparam bit HS_ACT  = (HS_POL != 0);
  localparam bit VS_ACT  = (VS_POL != 0);

  if (H_TOT_L > (1 << COORD_W) - 1 || V_TOT_L > (1 << COORD_W) - 1 || CE_DIV < 1) begin : g_param_check
    $error("vga_timing_gen: axis totals must fit the coordinate width and CE_DIV must be >= 1");
  end

  logic [CE_W-1:0] ce_cnt_q, ce_cnt_d;
  logic            tick;
  logic            v_inc;
  coord_t          h_cnt, v_cnt;
  logic            h_first, v_first, h_active, v_active, h_sync, v_sync;

  logic   pix_ce_q, pix_ce_d;
  logic   hsync_q, hsync_d;
  logic   vsync_q, vsync_d;
  logic   de_q, de_d;
  coord_t x_q, x_d;
  coord_t y_q, y_d;
  logic   ls_q, ls_d;
  logic   fs_q, fs_d;

  assign tick = vga.en && (ce_cnt_q == CE_W'(CE_DIV - 1));

  always_comb begin
    ce_cnt_d = ce_cnt_q;
    if (!vga.en || tick) begin
      ce_cnt_d = '0;
    end else begin
      ce_cnt_d = ce_cnt_q + 1'b1;
    end
  end

  // Vertical advances on the tick that takes h from its last column back to 0.
  assign v_inc = tick && (h_cnt == coord_t'(H_TOT_L - 1));

  vga_axis_cnt #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)) u_h_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (!vga.en),
    .inc_i    (tick),
    .cnt_o    (h_cnt),
    .first_o  (h_first),
    .active_o (h_active),
    .sync_o   (h_sync)
  );

  vga_axis_cnt #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)) u_v_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (!vga.en),
    .inc_i    (v_inc),
    .cnt_o    (v_cnt),
    .first_o  (v_first),
    .active_o (v_active),
    .sync_o   (v_sync)
  );

  always_comb begin
    pix_ce_d = tick;
    hsync_d  = hsync_q;
    vsync_d  = vsync_q;
    de_d     = de_q;
    x_d      = x_q;
    y_d      = y_q;
    ls_d     = ls_q;
    fs_d     = fs_q;
    if (!vga.en) begin
      hsync_d = ~HS_ACT;
      vsync_d = ~VS_ACT;
      de_d    = 1'b0;
      x_d     = '0;
      y_d     = '0;
      ls_d    = 1'b0;
      fs_d    = 1'b0;
    end else if (tick) begin
      de_d    = h_active && v_active;
      x_d     = de_d ? h_cnt : '0;
      y_d     = de_d ? v_cnt : '0;
      hsync_d = h_sync ? HS_ACT : ~HS_ACT;
      vsync_d = v_sync ? VS_ACT : ~VS_ACT;
      ls_d    = h_first;
      fs_d    = h_first && v_first;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ce_cnt_q <= '0;
      pix_ce_q <= 1'b0;
      hsync_q  <= ~HS_ACT;
      vsync_q  <= ~VS_ACT;
      de_q     <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      ls_q     <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      ce_cnt_q <= ce_cnt_d;
      pix_ce_q <= pix_ce_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      de_q     <= de_d;
      x_q      <= x_d;
      y_q      <= y_d;
      ls_q     <= ls_d;
      fs_q     <= fs_d;
    end
  end

  assign vga.pix_ce      = pix_ce_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.de          = de_q;
  assign vga.x           = x_q;
  assign vga.y           = y_q;
  assign vga.line_start  = ls_q;
  assign vga.frame_start = fs_q;

endmodule
